// File: rtl/cw_pkg.sv
// cw_pkg: shared widths, scalar types and FSM state encoding for the
// cw_winnow receiver-side winnowing stage.
package cw_pkg;

    localparam int CTR_W   = 16;
    localparam int TAG_W   = 16;
    localparam int CACHE_N = 64;
    localparam int DATA_W  = 8;
    localparam int IDX_W   = $clog2(CACHE_N);

    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [CTR_W-1:0] ctr_t;
    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/cw_used_map.sv
// cw_used_map: one flag per cache entry recording that its tag has already
// authenticated a packet. Clear-all takes priority over a same-cycle set.
module cw_used_map
    import cw_pkg::*;
#(
    parameter int N  = CACHE_N,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_set,
    input  logic [IW-1:0] i_set_idx,
    input  logic [IW-1:0] i_rd_idx,
    output logic          o_rd_bit
);

    logic [N-1:0] r_map;

    // Used-flag storage: async reset, synchronous clear-all, single-bit set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_map <= {N{1'b0}};
        end else if (i_clr) begin
            r_map <= {N{1'b0}};
        end else if (i_set) begin
            r_map[i_set_idx] <= 1'b1;
        end else begin
            r_map <= r_map;
        end
    end

    assign o_rd_bit = r_map[i_rd_idx];

endmodule

// File: rtl/cw_winnow.sv
// cw_winnow: scans each incoming packet's tag against the MAC cache, one
// entry per cycle. An unused matching entry makes the packet wheat and
// yields its counter; otherwise the packet is chaff.
// Build option: define CW_CHAFF_PASS_EN to emit chaff on the output
// (out_wheat = 0, out_ctr = 0); by default chaff is dropped silently.
module cw_winnow
    import cw_pkg::*;
#(
    parameter int ctrsize   = CTR_W,
    parameter int tagsize   = TAG_W,
    parameter int cachesize = CACHE_N,
    parameter int datasize  = DATA_W
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [cachesize-1:0][tagsize-1:0]  maccache,
    input  logic [ctrsize-1:0]                 cache_base,
    input  logic                               cache_load,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [datasize-1:0]                in_data,
    input  logic [tagsize-1:0]                 in_tag,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [datasize-1:0]                out_data,
    output logic [ctrsize-1:0]                 out_ctr,
    output logic                               out_wheat,
    output logic [ctrsize-1:0]                 wheat_cnt,
    output logic [ctrsize-1:0]                 chaff_cnt
);

    localparam int                IW       = $clog2(cachesize);
    localparam logic [IW-1:0]     LAST_IDX = IW'(cachesize - 1);
    localparam logic [ctrsize-1:0] CTR_MAX = {ctrsize{1'b1}};

    state_t              r_state;
    logic [IW-1:0]       r_idx;
    logic [tagsize-1:0]  r_tag;
    logic [datasize-1:0] r_data;
    logic [ctrsize-1:0]  r_ctr;
    logic                r_wheat;
    logic                r_out_valid;
    logic [ctrsize-1:0]  r_wheat_cnt;
    logic [ctrsize-1:0]  r_chaff_cnt;
    logic                r_load_pend;

    logic                w_used;
    logic                w_load_req;
    logic                w_accept;
    logic                w_hit;
    logic                w_last;
    logic                w_miss_end;
    logic                w_clr;
    logic [ctrsize-1:0]  w_hit_ctr;

    // Handshake, compare and bitmap-control decode for the current cycle.
    always_comb begin
        w_load_req = cache_load | r_load_pend;
        // Gated by rst_n so nothing is accepted while reset is held.
        in_ready   = rst_n & (r_state == IDLE) & ~w_load_req;
        w_accept   = in_valid & in_ready;
        w_hit      = (r_state == SCAN) && (maccache[r_idx] == r_tag) && !w_used;
        w_last     = (r_idx == LAST_IDX);
        w_miss_end = (r_state == SCAN) && !w_hit && w_last;
        w_clr      = (r_state == IDLE) && w_load_req;
        w_hit_ctr  = cache_base + ctrsize'(r_idx);
    end

    cw_used_map #(
        .N  (cachesize),
        .IW (IW)
    ) u_used_map (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_clr),
        .i_set     (w_hit),
        .i_set_idx (r_idx),
        .i_rd_idx  (r_idx),
        .o_rd_bit  (w_used)
    );

    // Main FSM: accept a packet, scan the cache, present the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= {IW{1'b0}};
            r_tag       <= {tagsize{1'b0}};
            r_data      <= {datasize{1'b0}};
            r_ctr       <= {ctrsize{1'b0}};
            r_wheat     <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_data  <= in_data;
                        r_tag   <= in_tag;
                        r_idx   <= {IW{1'b0}};
                        r_state <= SCAN;
                    end
                end
                SCAN: begin
                    if (w_hit) begin
                        r_ctr       <= w_hit_ctr;
                        r_wheat     <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= OUT;
                    end else if (!w_last) begin
                        r_idx <= r_idx + IW'(1);
                    end else begin
                        r_ctr   <= {ctrsize{1'b0}};
                        r_wheat <= 1'b0;
`ifdef CW_CHAFF_PASS_EN
                        r_out_valid <= 1'b1;
                        r_state     <= OUT;
`else
                        r_state     <= IDLE;
`endif
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    // Saturating wheat/chaff statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wheat_cnt <= {ctrsize{1'b0}};
            r_chaff_cnt <= {ctrsize{1'b0}};
        end else begin
            if (w_miss_end && (r_chaff_cnt != CTR_MAX)) begin
                r_chaff_cnt <= r_chaff_cnt + ctrsize'(1);
            end
            if ((r_state == OUT) && out_ready && r_wheat && (r_wheat_cnt != CTR_MAX)) begin
                r_wheat_cnt <= r_wheat_cnt + ctrsize'(1);
            end
        end
    end

    // A cache load seen while busy is remembered and applied on return to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_load_pend <= 1'b0;
        end else if (r_state == IDLE) begin
            r_load_pend <= 1'b0;
        end else if (cache_load) begin
            r_load_pend <= 1'b1;
        end else begin
            r_load_pend <= r_load_pend;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_data;
    assign out_ctr   = r_ctr;
    assign out_wheat = r_wheat;
    assign wheat_cnt = r_wheat_cnt;
    assign chaff_cnt = r_chaff_cnt;

endmodule

// File: tb/tb_cw_winnow.sv
// tb_cw_winnow: directed scenarios plus randomized packets, checked against
// a lookup-table reference model (lowest unused matching entry wins).
module tb_cw_winnow;
    import cw_pkg::*;

    localparam int CN = 64;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [CN-1:0][15:0]   maccache;
    logic [15:0]           cache_base;
    logic                  cache_load;
    logic                  in_valid;
    logic                  in_ready;
    logic [7:0]            in_data;
    logic [15:0]           in_tag;
    logic                  out_valid;
    logic                  out_ready;
    logic [7:0]            out_data;
    logic [15:0]           out_ctr;
    logic                  out_wheat;
    logic [15:0]           wheat_cnt;
    logic [15:0]           chaff_cnt;

    always #5 clk = ~clk;

    cw_winnow dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .maccache   (maccache),
        .cache_base (cache_base),
        .cache_load (cache_load),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ctr    (out_ctr),
        .out_wheat  (out_wheat),
        .wheat_cnt  (wheat_cnt),
        .chaff_cnt  (chaff_cnt)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit m_used [CN];
    int m_wheat = 0;
    int m_chaff = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Cache contents must not move while a packet is being processed.
    logic [CN-1:0][15:0] prev_cache;
    logic [15:0]         prev_base;
    always @(posedge clk) begin
        if (rst_n === 1'b1 && dut.r_state != IDLE)
            assert (maccache == prev_cache && cache_base == prev_base)
            else $error("cache inputs changed while busy");
        prev_cache <= maccache;
        prev_base  <= cache_base;
    end

    // Watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic clear_model();
        for (int j = 0; j < CN; j++) m_used[j] = 1'b0;
    endtask

    task automatic load_cache();
        @(negedge clk);
        cache_load = 1'b1;
        #1 chk("load_blocks_ready", in_ready, 1'b0);
        @(negedge clk);
        cache_load = 1'b0;
        clear_model();
    endtask

    task automatic do_pkt(input logic [7:0] d, input logic [15:0] t, input int hold, input bit load_in_hold);
        int hit = -1;
        int lat;
        int n;
        logic [15:0] exp_ctr;
        bit exp_wheat;
        for (int j = 0; j < CN; j++)
            if (hit < 0 && maccache[j] == t && !m_used[j]) hit = j;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 8) begin @(negedge clk); n++; end
        chk("ready_before_pkt", in_ready, 1'b1);
        in_valid = 1'b1; in_data = d; in_tag = t;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!out_valid && !in_ready && lat < 100);
        if (hit >= 0) begin
            exp_ctr = cache_base + 16'(hit);
            exp_wheat = 1'b1;
            m_used[hit] = 1'b1;
            chk("hit_latency", lat, hit + 1);
        end else begin
            exp_ctr = 16'h0000;
            exp_wheat = 1'b0;
            m_chaff++;
            chk("miss_latency", lat, CN);
`ifndef CW_CHAFF_PASS_EN
            chk("chaff_no_output", out_valid, 1'b0);
            chk("chaff_back_idle", in_ready, 1'b1);
            chk("chaff_cnt_drop", chaff_cnt, m_chaff);
            return;
`endif
        end
        chk("out_valid", out_valid, 1'b1);
        chk("out_wheat", out_wheat, exp_wheat);
        chk("out_ctr", out_ctr, exp_ctr);
        chk("out_data", out_data, d);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            cache_load = (load_in_hold && i == 1);
        end
        cache_load = 1'b0;
        if (hold > 0) begin
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_ctr", out_ctr, exp_ctr);
            chk("hold_wheat", out_wheat, exp_wheat);
            chk("hold_data", out_data, d);
            chk("hold_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        if (exp_wheat) m_wheat++;
        chk("valid_drop", out_valid, 1'b0);
        if (load_in_hold) begin
            chk("pend_blocks_ready", in_ready, 1'b0);
            @(negedge clk);
            clear_model();
        end
        chk("ready_after_out", in_ready, 1'b1);
        chk("wheat_cnt", wheat_cnt, m_wheat);
        chk("chaff_cnt", chaff_cnt, m_chaff);
    endtask

    initial begin
        rst_n = 1'b0; cache_load = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = 8'h00; in_tag = 16'h0000; cache_base = 16'h0100;
        for (int j = 0; j < CN; j++) maccache[j] = 16'h4000 + 16'(j);
        maccache[5] = 16'hBEEF;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_ctr", out_ctr, 16'h0000);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_out_wheat", out_wheat, 1'b0);
        chk("rst_wheat_cnt", wheat_cnt, 16'h0000);
        chk("rst_chaff_cnt", chaff_cnt, 16'h0000);
        rst_n = 1'b1;
        clear_model();
        load_cache();

        // Basic hit, replay, reload.
        do_pkt(8'h11, 16'hBEEF, 0, 1'b0);
        do_pkt(8'h22, 16'hBEEF, 0, 1'b0);
        load_cache();
        do_pkt(8'h33, 16'hBEEF, 1, 1'b0);
        // Absent tag.
        do_pkt(8'h44, 16'h1234, 2, 1'b0);
        // Counter wrap and duplicates.
        @(negedge clk);
        cache_base = 16'hFFFE;
        maccache[3] = 16'hC0DE;
        load_cache();
        do_pkt(8'h55, 16'hC0DE, 0, 1'b0);
        @(negedge clk);
        maccache[2] = 16'hD00D;
        maccache[9] = 16'hD00D;
        load_cache();
        do_pkt(8'h66, 16'hD00D, 0, 1'b0);
        do_pkt(8'h77, 16'hD00D, 0, 1'b0);
        // Output backpressure with a cache load while busy.
        do_pkt(8'h88, 16'h4000 + 16'd40, 10, 1'b1);
        do_pkt(8'h99, 16'h4000 + 16'd40, 0, 1'b0);

        // Reset in the middle of a scan.
        do_pkt(8'hAA, 16'h4000 + 16'd12, 0, 1'b0);
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'hBB; in_tag = 16'h7777;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_in_ready", in_ready, 1'b0);
        chk("abort_out_ctr", out_ctr, 16'h0000);
        chk("abort_out_data", out_data, 8'h00);
        chk("abort_wheat_cnt", wheat_cnt, 16'h0000);
        chk("abort_chaff_cnt", chaff_cnt, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        m_wheat = 0; m_chaff = 0;
        clear_model();
        #1 chk("post_rst_ready", in_ready, 1'b1);
        do_pkt(8'hCC, 16'h4000 + 16'd12, 0, 1'b0);

        // Randomized traffic with a small tag alphabet for duplicates and replays.
        @(negedge clk);
        cache_base = 16'($urandom);
        for (int j = 0; j < CN; j++) maccache[j] = 16'hA000 + 16'($urandom_range(0, 23));
        load_cache();
        for (int p = 0; p < 30; p++) begin
            if ($urandom_range(0, 7) == 0) begin
                @(negedge clk);
                cache_base = 16'($urandom);
                for (int j = 0; j < CN; j++) maccache[j] = 16'hA000 + 16'($urandom_range(0, 23));
                load_cache();
            end
            do_pkt(8'($urandom), 16'hA000 + 16'($urandom_range(0, 29)), $urandom_range(0, 3), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
